// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU results and queued load returns onto the single
// register-file write port, with a starvation guard and a pending-destination mask.
`default_nettype none

module regfile_writeback #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [3:0]  alu_dest_i,
    input  logic [15:0] alu_data_i,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic [3:0]  mem_dest_i,
    input  logic [15:0] mem_data_i,
    output logic        write_en_o,
    output logic [3:0]  write_address_o,
    output logic [15:0] wr_data_o,
    output logic        pc_write_o,
    output logic [15:0] pending_o,
    output logic        ovf_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [3:0]    fifo_dest_q [FIFO_DEPTH];
    logic [15:0]   fifo_data_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          ovf_q;
    logic          we_q, we_d;
    logic [3:0]    addr_q, addr_d;
    logic [15:0]   data_q, data_d;
    logic          pc_q, pc_d;

    logic fifo_nonempty, alu_win, pop, push;

    assign fifo_nonempty = (count_q != '0);
    assign mem_ready_o   = (count_q < DEPTH_C);
    assign alu_ready_o   = !(fifo_nonempty && (starve_q == LIMIT_C));
    assign alu_win       = alu_valid_i && alu_ready_o;
    assign pop           = !alu_win && fifo_nonempty;
    assign push          = mem_valid_i && mem_ready_o;

    always_comb begin
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        count_d  = count_q;
        starve_d = starve_q;
        if (alu_win) begin
            we_d   = 1'b1;
            addr_d = alu_dest_i;
            data_d = alu_data_i;
        end else if (pop) begin
            we_d   = 1'b1;
            addr_d = fifo_dest_q[rd_ptr_q];
            data_d = fifo_data_q[rd_ptr_q];
        end
        pc_d = we_d && (addr_d == 4'hF);

        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;

        // Count only ALU wins that actually bypass a waiting load.
        if (pop || !fifo_nonempty)
            starve_d = '0;
        else if (alu_win && starve_q != LIMIT_C)
            starve_d = starve_q + 1'b1;
    end

    // Entry i is live when its distance from the read pointer is below count.
    always_comb begin
        logic [AW-1:0] offset;
        pending_o = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            offset = AW'(i) - rd_ptr_q;
            if ({1'b0, offset} < count_q)
                pending_o[fifo_dest_q[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            ovf_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            pc_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_d;
            starve_q <= starve_d;
            if (mem_valid_i && !mem_ready_o) ovf_q <= 1'b1;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            pc_q     <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dest_q[wr_ptr_q] <= mem_dest_i;
            fifo_data_q[wr_ptr_q] <= mem_data_i;
        end
    end

    assign write_en_o      = we_q;
    assign write_address_o = addr_q;
    assign wr_data_o       = data_q;
    assign pc_write_o      = pc_q;
    assign ovf_o           = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with immediate-assertion checks.
`default_nettype none

module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [3:0]  alu_dest, mem_dest, waddr;
    logic [15:0] alu_data, mem_data, wdata, pending;
    logic        we, pcw, ovf;

    int n_cmp = 0;
    int n_err = 0;

    regfile_writeback #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alu_valid_i     (alu_valid),
        .alu_ready_o     (alu_ready),
        .alu_dest_i      (alu_dest),
        .alu_data_i      (alu_data),
        .mem_valid_i     (mem_valid),
        .mem_ready_o     (mem_ready),
        .mem_dest_i      (mem_dest),
        .mem_data_i      (mem_data),
        .write_en_o      (we),
        .write_address_o (waddr),
        .wr_data_o       (wdata),
        .pc_write_o      (pcw),
        .pending_o       (pending),
        .ovf_o           (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [3:0] a, input logic [15:0] d);
        chk({tag, ".we"},   32'(we),    32'd1);
        chk({tag, ".addr"}, 32'(waddr), 32'(a));
        chk({tag, ".data"}, 32'(wdata), 32'(d));
    endtask

    task automatic alu(input logic v, input logic [3:0] d, input logic [15:0] x);
        alu_valid = v; alu_dest = d; alu_data = x;
    endtask

    task automatic mem(input logic v, input logic [3:0] d, input logic [15:0] x);
        mem_valid = v; mem_dest = d; mem_data = x;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        alu(1'b0, 4'h0, 16'h0);
        mem(1'b0, 4'h0, 16'h0);
        tick(); tick();
        chk("rst.we",        32'(we),        32'd0);
        chk("rst.addr",      32'(waddr),     32'd0);
        chk("rst.data",      32'(wdata),     32'd0);
        chk("rst.pc",        32'(pcw),       32'd0);
        chk("rst.pending",   32'(pending),   32'd0);
        chk("rst.ovf",       32'(ovf),       32'd0);
        chk("rst.mem_ready", 32'(mem_ready), 32'd1);
        chk("rst.alu_ready", 32'(alu_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // ALU write
        alu(1'b1, 4'd5, 16'hBEEF);
        tick();
        alu(1'b0, 4'd0, 16'h0);
        chk_wr("alu", 4'd5, 16'hBEEF);
        chk("alu.pc", 32'(pcw), 32'd0);
        tick();
        chk("alu.we_off", 32'(we),    32'd0);
        chk("alu.hold",   32'(waddr), 32'd5);

        // Load latency
        mem(1'b1, 4'd3, 16'h1234);
        tick();
        mem(1'b0, 4'd0, 16'h0);
        chk("ld.pending1", 32'(pending), 32'h0008);
        chk("ld.we1",      32'(we),      32'd0);
        tick();
        chk_wr("ld", 4'd3, 16'h1234);
        chk("ld.pending2", 32'(pending), 32'h0000);

        // PC write
        alu(1'b1, 4'd15, 16'h0100);
        tick();
        alu(1'b0, 4'd0, 16'h0);
        chk_wr("pc", 4'd15, 16'h0100);
        chk("pc.flag", 32'(pcw), 32'd1);
        tick();
        chk("pc.flag_off", 32'(pcw), 32'd0);
        chk("pc.we_off",   32'(we),  32'd0);

        // Fill and overflow under a held ALU stream
        alu(1'b1, 4'd10, 16'hA0A0);
        for (int i = 1; i <= 4; i++) begin
            mem(1'b1, 4'(i), 16'(i * 16'h1111));
            tick();
            chk_wr("fill.alu", 4'd10, 16'hA0A0);
        end
        chk("fill.mem_ready", 32'(mem_ready), 32'd0);
        chk("fill.pending",   32'(pending),   32'h001E);
        chk("fill.alu_ready", 32'(alu_ready), 32'd0);
        chk("fill.ovf0",      32'(ovf),       32'd0);
        mem(1'b1, 4'd5, 16'h5555);
        tick();
        alu(1'b0, 4'd0, 16'h0);
        mem(1'b0, 4'd0, 16'h0);
        chk("ovf.set",       32'(ovf),       32'd1);
        chk_wr("drain1", 4'd1, 16'h1111);
        chk("ovf.mem_ready", 32'(mem_ready), 32'd1);
        chk("ovf.pending",   32'(pending),   32'h001C);
        tick(); chk_wr("drain2", 4'd2, 16'h2222);
        tick(); chk_wr("drain3", 4'd3, 16'h3333);
        tick(); chk_wr("drain4", 4'd4, 16'h4444);
        chk("drain.pending", 32'(pending), 32'h0000);
        tick();
        chk("drain.we_off", 32'(we),    32'd0);
        chk("drain.hold",   32'(wdata), 32'h4444);

        // Starvation: one load queued behind an ALU write, then ALU 6,7,8,9
        alu(1'b1, 4'd2, 16'h0202);
        mem(1'b1, 4'd12, 16'hCCCC);
        tick();
        mem(1'b0, 4'd0, 16'h0);
        chk_wr("stv.pre", 4'd2, 16'h0202);
        for (int d = 6; d <= 8; d++) begin
            alu(1'b1, 4'(d), 16'(d * 16'h0101));
            tick();
            chk_wr("stv.alu", 4'(d), 16'(d * 16'h0101));
        end
        chk("stv.alu_ready0", 32'(alu_ready), 32'd0);
        alu(1'b1, 4'd9, 16'h0909);
        tick();
        chk_wr("stv.load", 4'd12, 16'hCCCC);
        chk("stv.alu_ready1", 32'(alu_ready), 32'd1);
        tick();
        alu(1'b0, 4'd0, 16'h0);
        chk_wr("stv.nine", 4'd9, 16'h0909);
        tick();
        chk("stv.we_off", 32'(we), 32'd0);

        // Reset mid-operation with three queued loads
        alu(1'b1, 4'd1, 16'h0001);
        for (int i = 13; i <= 15; i++) begin
            mem(1'b1, 4'(i), 16'hF000 | 16'(i));
            tick();
        end
        alu(1'b0, 4'd0, 16'h0);
        mem(1'b0, 4'd0, 16'h0);
        chk("mid.pending", 32'(pending), 32'hE000);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.we",        32'(we),        32'd0);
        chk("mid.pending0",  32'(pending),   32'd0);
        chk("mid.mem_ready", 32'(mem_ready), 32'd1);
        chk("mid.ovf",       32'(ovf),       32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("post.we1", 32'(we), 32'd0);
        tick();
        chk("post.we2",      32'(we),      32'd0);
        chk("post.pending",  32'(pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
